// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake and an iterative shifter.
// Define ALU_SHIFT_FAST_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  illegal_op,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_next;
  logic [DATA_WIDTH-1:0] acc, acc_next, res_comb;
  logic [SHAMT_W-1:0] cnt, shamt;
  logic [3:0] shift_op;
  logic zero_comb, ill_comb, is_shift, accept, go_shift;
  assign shamt = SrcB[SHAMT_W-1:0];
  assign is_shift = Operation inside {4'b0101, 4'b0111, 4'b1101};
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign resp_valid = state == DONE;
`ifdef ALU_SHIFT_FAST_EN
  assign go_shift = 1'b0;
  assign busy = 1'b0;
`else
  assign go_shift = is_shift && shamt != '0;
  assign busy = state == SHIFT;
`endif
  // SLL shifts left; SRA refills the MSB with the sign, SRL with zero
  assign acc_next = shift_op == 4'b0101 ? acc << 1
                  : {shift_op == 4'b0111 && acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
  always_comb begin
    res_comb = '0;
    ill_comb = 1'b0;
    case (Operation)
      4'b0000: res_comb = SrcA & SrcB;
      4'b0001: res_comb = SrcA | SrcB;
      4'b0010: res_comb = SrcA + SrcB;
      4'b0011: res_comb = SrcA - SrcB;
      4'b0100: res_comb = SrcA ^ SrcB;
`ifdef ALU_SHIFT_FAST_EN
      4'b0101: res_comb = SrcA << shamt;
      4'b0111: res_comb = $unsigned($signed(SrcA) >>> shamt);
      4'b1101: res_comb = SrcA >> shamt;
`else
      4'b0101, 4'b0111, 4'b1101: res_comb = SrcA;
`endif
      4'b1000: res_comb = SrcA - SrcB;
      4'b1100: res_comb = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      default: ill_comb = 1'b1;
    endcase
    zero_comb = Operation == 4'b1000 ? SrcA == SrcB : res_comb == '0;
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = go_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Result <= '0;
      Zero <= 1'b0;
      illegal_op <= 1'b0;
      acc <= '0;
      cnt <= '0;
      shift_op <= '0;
    end else if (accept && go_shift) begin
      acc <= SrcA;
      cnt <= shamt;
      shift_op <= Operation;
    end else if (accept) begin
      Result <= res_comb;
      Zero <= zero_comb;
      illegal_op <= ill_comb;
    end else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - SHAMT_W'(1);
      if (cnt == SHAMT_W'(1)) begin
        Result <= acc_next;
        Zero <= acc_next == '0;
        illegal_op <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
`ifdef ALU_SHIFT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, resp_ready = 1'b0;
  logic req_ready, resp_valid, Zero, illegal_op, busy;
  logic [3:0] Operation = '0;
  logic [31:0] SrcA = '0, SrcB = '0, Result;
  int checks = 0, errors = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .Result(Result), .Zero(Zero),
    .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                output logic [31:0] r, output logic z, output logic il,
                                output int lat);
    int sh;
    sh = int'(b % 32);
    il = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd7:  r = $unsigned($signed(a) >>> sh);
      4'd13: r = a >> sh;
      4'd8:  r = a - b;
      4'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; il = 1'b1; end
    endcase
    z = (op == 4'd8) ? (a == b) : (r == 32'd0);
    lat = ((op == 4'd5 || op == 4'd7 || op == 4'd13) && !FAST) ? 1 + sh : 1;
  endfunction

  // Issues one request, waits for the response, then completes the handshake.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b,
                        output logic [31:0] r, output logic z, output logic il,
                        output int lat, output int bcnt);
    int g;
    Operation = op; SrcA = a; SrcB = b; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1; bcnt = 0;
    while (!resp_valid && lat < 100) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    r = Result; z = Zero; il = illegal_op;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, busy, Zero, illegal_op} !== 5'b0 || Result !== 32'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b z=%b ill=%b res=%h required all zero",
               req_ready, resp_valid, busy, Zero, illegal_op, Result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] r;
    logic z, il;
    int lat, bc;
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, r, z, il, lat, bc);
    checks++;
    if ({r, z, il} !== {32'd0, 1'b1, 1'b0} || lat !== 1) begin
      errors++;
      $display("FAIL add_wrap: res=%h z=%b ill=%b lat=%0d required 0 1 0 1", r, z, il, lat);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_drop: resp_valid=%b required 0", resp_valid);
    end
    run_op(4'b0101, 32'd1, 32'd5, r, z, il, lat, bc);
    checks++;
    if (r !== 32'h20 || z !== 1'b0 || lat !== (FAST ? 1 : 6) || bc !== (FAST ? 0 : 5)) begin
      errors++;
      $display("FAIL sll5: res=%h z=%b lat=%0d busy_cycles=%0d required 20 0 %0d %0d",
               r, z, lat, bc, FAST ? 1 : 6, FAST ? 0 : 5);
    end
    run_op(4'b0111, 32'h8000_0000, 32'hFFFF_FFFF, r, z, il, lat, bc);
    checks++;
    if (r !== 32'hFFFF_FFFF || lat !== (FAST ? 1 : 32)) begin
      errors++;
      $display("FAIL sra31: res=%h lat=%0d required ffffffff %0d", r, lat, FAST ? 1 : 32);
    end
    run_op(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, r, z, il, lat, bc);
    checks++;
    if (r !== 32'h1 || z !== 1'b0 || lat !== (FAST ? 1 : 32)) begin
      errors++;
      $display("FAIL srl31: res=%h z=%b lat=%0d required 1 0 %0d", r, z, lat, FAST ? 1 : 32);
    end
    run_op(4'b1100, 32'hFFFF_FFFE, 32'd1, r, z, il, lat, bc);
    checks++;
    if (r !== 32'd1 || z !== 1'b0 || il !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg: res=%h z=%b ill=%b required 1 0 0", r, z, il);
    end
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, r, z, il, lat, bc);
    checks++;
    if (r !== 32'd0 || z !== 1'b1 || il !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL illegal: res=%h z=%b ill=%b lat=%0d required 0 1 1 1", r, z, il, lat);
    end
    run_op(4'b1000, 32'h1234, 32'h1234, r, z, il, lat, bc);
    checks++;
    if (r !== 32'd0 || z !== 1'b1 || il !== 1'b0) begin
      errors++;
      $display("FAIL eq_equal: res=%h z=%b ill=%b required 0 1 0", r, z, il);
    end
  endtask

  task automatic test_random;
    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd13, 4'd8, 4'd12, 4'd6, 4'd15};
    logic [31:0] a, b, r, er;
    logic z, il, ez, eil;
    int lat, bc, elat;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      model(op, a, b, er, ez, eil, elat);
      run_op(op, a, b, r, z, il, lat, bc);
      checks++;
      if (r !== er || z !== ez || il !== eil || lat !== elat) begin
        errors++;
        $display("FAIL random[%0d] op=%h a=%h b=%h: res=%h z=%b ill=%b lat=%0d required %h %b %b %0d",
                 i, op, a, b, r, z, il, lat, er, ez, eil, elat);
      end
    end
  endtask

  task automatic test_back_to_back;
    int seen;
    Operation = 4'b0011; SrcA = 32'd7; SrcB = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    Operation = 4'b0010; SrcA = 32'd3; SrcB = 32'd4;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || Result !== 32'd0 || Zero !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: vld=%b res=%h z=%b rdy=%b required 1 0 1 0",
                 i, resp_valid, Result, Zero, req_ready);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: vld=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || Result !== 32'd7 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL held_request: vld=%b res=%h z=%b required 1 7 0", resp_valid, Result, Zero);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    seen = 0;
    repeat (4) begin seen += int'(resp_valid); @(posedge clk); #1; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL single_accept: extra response cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    Operation = 4'b1101; SrcA = 32'hFFFF_0000; SrcB = 32'd20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || Result !== 32'd0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: vld=%b busy=%b res=%h rdy=%b required 0 0 0 0",
               resp_valid, busy, Result, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort: got %b required 1", req_ready);
    end
    seen = 0;
    repeat (30) begin @(posedge clk); #1; seen += int'(resp_valid); end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL stale_response: resp_valid cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
